// File: rtl/hd44780_write_sequencer_if.sv
// Upstream byte handshake plus HD44780 write-bus pins, bundled for the
// sequencer (slave) and whatever feeds it or observes the pins (master).
interface hd44780_write_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;
    logic       busy;

    modport master (
        output in_valid,
        output in_rs,
        output in_data,
        input  in_ready,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_e,
        input  lcd_db,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_rs,
        input  in_data,
        output in_ready,
        output lcd_rs,
        output lcd_rw,
        output lcd_e,
        output lcd_db,
        output busy
    );
endinterface

// File: rtl/hd44780_write_sequencer.sv
// Serialises command/data bytes onto the HD44780 write bus with setup,
// enable-pulse, hold and execution-wait timing counted in clk cycles.
module hd44780_write_sequencer #(
    parameter int FOUR_BIT    = 0,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic clk,
    input  logic rst,
    hd44780_write_sequencer_if.slave bus
);

    localparam int MAX_AB = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int MAX_CD = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_AD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_T  = (MAX_AD > T_EXEC_LONG) ? MAX_AD : T_EXEC_LONG;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] C_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] C_EN    = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] C_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] C_LONG  = CW'(T_EXEC_LONG - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EN    = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;

    if (T_SETUP < 1) begin : g_bad_setup
        $error("T_SETUP must be >= 1");
    end
    if (T_EN_HIGH < 1) begin : g_bad_en
        $error("T_EN_HIGH must be >= 1");
    end
    if (T_HOLD < 1) begin : g_bad_hold
        $error("T_HOLD must be >= 1");
    end
    if (T_EXEC < 1) begin : g_bad_exec
        $error("T_EXEC must be >= 1");
    end
    if (T_EXEC_LONG < 1) begin : g_bad_long
        $error("T_EXEC_LONG must be >= 1");
    end

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          r_nib;
    logic          r_lcd_e;
    logic          r_lcd_rs;
    logic [7:0]    r_lcd_db;

    logic          w_zero;
    logic          w_long;
    logic          w_split;
    logic [7:0]    w_first_db;
    logic [7:0]    w_low_db;
    logic [CW-1:0] w_exec_ld;

    assign w_zero     = (r_cnt == '0);
    assign w_split    = (FOUR_BIT != 0);
    // Clear display and return home need the long execution wait.
    assign w_long     = !r_rs && (r_data != 8'h00) && (r_data <= 8'h03);
    assign w_exec_ld  = w_long ? C_LONG : C_EXEC;
    assign w_first_db = w_split ? {bus.in_data[7:4], 4'h0} : bus.in_data;
    assign w_low_db   = {r_data[3:0], 4'h0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rs     <= 1'b0;
            r_data   <= 8'h00;
            r_nib    <= 1'b0;
            r_lcd_e  <= 1'b0;
            r_lcd_rs <= 1'b0;
            r_lcd_db <= 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_rs     <= bus.in_rs;
                        r_data   <= bus.in_data;
                        r_nib    <= 1'b0;
                        r_lcd_rs <= bus.in_rs;
                        r_lcd_db <= w_first_db;
                        r_cnt    <= C_SETUP;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_zero) begin
                        r_lcd_e <= 1'b1;
                        r_cnt   <= C_EN;
                        r_state <= S_EN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_EN: begin
                    if (w_zero) begin
                        r_lcd_e <= 1'b0;
                        r_cnt   <= C_HOLD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_zero) begin
                        // Low nibble goes out only after the high one is held.
                        if (w_split && !r_nib) begin
                            r_nib    <= 1'b1;
                            r_lcd_db <= w_low_db;
                            r_cnt    <= C_SETUP;
                            r_state  <= S_SETUP;
                        end else begin
                            r_cnt    <= w_exec_ld;
                            r_state  <= S_EXEC;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_lcd_e <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_e    = r_lcd_e;
    assign bus.lcd_rs   = r_lcd_rs;
    assign bus.lcd_db   = r_lcd_db;

endmodule

// File: tb/tb_hd44780_write_sequencer.sv
// Bench for hd44780_write_sequencer: one 8-bit and one 4-bit instance,
// expected E pulses and busy windows queued at drive time, checked at negedge.
module tb_hd44780_write_sequencer;

    localparam int TS = 2;
    localparam int TE = 12;
    localparam int TH = 2;
    localparam int TX = 20;
    localparam int TL = 100;

    typedef struct {
        logic [7:0] db;
        logic       rs;
        int         lo;
    } pulse_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hd44780_write_sequencer_if if8 ();
    hd44780_write_sequencer_if if4 ();

    hd44780_write_sequencer #(
        .FOUR_BIT(0), .T_SETUP(TS), .T_EN_HIGH(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)
    ) u_dut8 (
        .clk(clk), .rst(rst), .bus(if8.slave)
    );

    hd44780_write_sequencer #(
        .FOUR_BIT(1), .T_SETUP(TS), .T_EN_HIGH(TE),
        .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)
    ) u_dut4 (
        .clk(clk), .rst(rst), .bus(if4.slave)
    );

    logic       w_e   [2];
    logic       w_rs  [2];
    logic       w_rw  [2];
    logic       w_rdy [2];
    logic       w_busy[2];
    logic [7:0] w_db  [2];

    assign w_e[0]    = if8.lcd_e;
    assign w_rs[0]   = if8.lcd_rs;
    assign w_rw[0]   = if8.lcd_rw;
    assign w_rdy[0]  = if8.in_ready;
    assign w_busy[0] = if8.busy;
    assign w_db[0]   = if8.lcd_db;
    assign w_e[1]    = if4.lcd_e;
    assign w_rs[1]   = if4.lcd_rs;
    assign w_rw[1]   = if4.lcd_rw;
    assign w_rdy[1]  = if4.in_ready;
    assign w_busy[1] = if4.busy;
    assign w_db[1]   = if4.lcd_db;

    int n_chk  = 0;
    int n_fail = 0;

    pulse_t qp0[$];
    pulse_t qp1[$];
    int     qb0[$];
    int     qb1[$];

    logic       p_e[2];
    logic       p_rdy[2];
    int         lo[2];
    int         hi[2];
    int         hold_left[2];
    int         pc[2];
    logic [7:0] r_db[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(int k);
        pulse_t p;
        bit     ok;
        int     eb;
        if (rst) begin
            p_e[k]       = 1'b0;
            p_rdy[k]     = 1'b1;
            lo[k]        = 0;
            hi[k]        = 0;
            hold_left[k] = 0;
            return;
        end
        chk("rw_zero", w_rw[k], 0);
        chk("busy_inv", w_busy[k], !w_rdy[k]);
        if (!w_rdy[k]) lo[k]++;
        if (w_e[k] && !p_e[k]) begin
            pc[k]++;
            ok = (k == 0) ? (qp0.size() != 0) : (qp1.size() != 0);
            chk("pulse_expected", ok, 1);
            if (ok) begin
                if (k == 0) p = qp0.pop_front();
                else        p = qp1.pop_front();
                chk("e_db", w_db[k], p.db);
                chk("e_rs", w_rs[k], p.rs);
                chk("setup_time", lo[k], p.lo);
            end
            r_db[k] = w_db[k];
            hi[k]   = 1;
        end else if (w_e[k]) begin
            hi[k]++;
            chk("db_stable_e", w_db[k], r_db[k]);
        end
        if (!w_e[k] && p_e[k]) begin
            chk("e_width", hi[k], TE);
            chk("hold_db", w_db[k], r_db[k]);
            hold_left[k] = TH - 1;
        end else if (!w_e[k] && hold_left[k] > 0) begin
            chk("hold_db", w_db[k], r_db[k]);
            hold_left[k]--;
        end
        if (w_rdy[k] && !p_rdy[k]) begin
            ok = (k == 0) ? (qb0.size() != 0) : (qb1.size() != 0);
            chk("window_expected", ok, 1);
            if (ok) begin
                if (k == 0) eb = qb0.pop_front();
                else        eb = qb1.pop_front();
                chk("busy_len", lo[k], eb);
            end
            lo[k] = 0;
        end
        p_e[k]   = w_e[k];
        p_rdy[k] = w_rdy[k];
    endtask

    task automatic tick();
        @(negedge clk);
        mon(0);
        mon(1);
    endtask

    task automatic wait_idle(int k);
        int n;
        n = 0;
        while (!w_rdy[k] && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", w_rdy[k], 1);
    endtask

    task automatic exp_push(int k, logic rs, logic [7:0] d);
        pulse_t p;
        int     ex;
        ex = (!rs && d >= 8'h01 && d <= 8'h03) ? TL : TX;
        p.rs = rs;
        if (k == 0) begin
            p.db = d;
            p.lo = TS + 1;
            qp0.push_back(p);
            qb0.push_back(TS + TE + TH + ex);
        end else begin
            p.db = {d[7:4], 4'h0};
            p.lo = TS + 1;
            qp1.push_back(p);
            p.db = {d[3:0], 4'h0};
            p.lo = 2 * TS + TE + TH + 1;
            qp1.push_back(p);
            qb1.push_back(2 * (TS + TE + TH) + ex);
        end
    endtask

    task automatic drive(int k, logic v, logic rs, logic [7:0] d);
        if (k == 0) begin
            if8.in_valid = v;
            if8.in_rs    = rs;
            if8.in_data  = d;
        end else begin
            if4.in_valid = v;
            if4.in_rs    = rs;
            if4.in_data  = d;
        end
    endtask

    task automatic send(int k, logic rs, logic [7:0] d);
        logic [7:0] first;
        first = (k == 0) ? d : {d[7:4], 4'h0};
        wait_idle(k);
        exp_push(k, rs, d);
        drive(k, 1'b1, rs, d);
        tick();
        chk("accepted", w_rdy[k], 0);
        chk("accept_rs", w_rs[k], rs);
        chk("accept_db", w_db[k], first);
        drive(k, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int pc0;
        int n;
        for (int k = 0; k < 2; k++) begin
            p_e[k] = 1'b0; p_rdy[k] = 1'b1; lo[k] = 0; hi[k] = 0;
            hold_left[k] = 0; pc[k] = 0; r_db[k] = 8'h00;
        end
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_e", w_e[k], 0);
            chk("rst_rs", w_rs[k], 0);
            chk("rst_rw", w_rw[k], 0);
            chk("rst_db", w_db[k], 8'h00);
            chk("rst_ready", w_rdy[k], 1);
            chk("rst_busy", w_busy[k], 0);
        end
        rst = 1'b0;
        tick();

        send(0, 1'b1, 8'h41);
        wait_idle(0);
        chk("db_after_exec", w_db[0], 8'h41);
        chk("rs_after_exec", w_rs[0], 1);

        send(0, 1'b0, 8'h01);
        send(0, 1'b0, 8'h04);
        send(0, 1'b0, 8'h03);
        send(0, 1'b0, 8'h00);
        send(0, 1'b1, 8'h02);
        wait_idle(0);

        send(1, 1'b0, 8'h28);
        send(1, 1'b0, 8'h02);
        send(1, 1'b1, 8'hA5);
        wait_idle(1);
        chk("nib_db_end", w_db[1], 8'h50);

        pc0 = pc[0];
        wait_idle(0);
        exp_push(0, 1'b1, 8'h48);
        exp_push(0, 1'b1, 8'h49);
        drive(0, 1'b1, 1'b1, 8'h48);
        tick();
        chk("b2b_acc1", w_rdy[0], 0);
        chk("b2b_db1", w_db[0], 8'h48);
        drive(0, 1'b1, 1'b1, 8'h49);
        wait_idle(0);
        tick();
        chk("b2b_no_gap", w_rdy[0], 0);
        chk("b2b_db2", w_db[0], 8'h49);
        drive(0, 1'b0, 1'b0, 8'h00);
        wait_idle(0);
        chk("b2b_pulses", pc[0] - pc0, 2);

        send(0, 1'b1, 8'h37);
        repeat (TS + TE + TH + 2) tick();
        pc0 = pc[0];
        drive(0, 1'b1, 1'b1, 8'h55);
        tick();
        drive(0, 1'b0, 1'b0, 8'h00);
        chk("exec_busy", w_rdy[0], 0);
        wait_idle(0);
        repeat (4) tick();
        chk("no_extra_pulse", pc[0] - pc0, 0);
        chk("db_kept", w_db[0], 8'h37);

        send(0, 1'b1, 8'h52);
        n = 0;
        while (!w_e[0] && n < 10) begin
            tick();
            n++;
        end
        chk("reached_en", w_e[0], 1);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_e", if8.lcd_e, 0);
        chk("arst_db", if8.lcd_db, 8'h00);
        chk("arst_rs", if8.lcd_rs, 0);
        chk("arst_ready", if8.in_ready, 1);
        chk("arst_busy", if8.busy, 0);
        qp0.delete();
        qb0.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", w_rdy[0], 1);
        send(0, 1'b0, 8'h30);
        wait_idle(0);
        chk("post_rst_db", w_db[0], 8'h30);
        chk("q_drained8", qp0.size() + qb0.size(), 0);
        chk("q_drained4", qp1.size() + qb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
